// File: rtl/seq_detect_param_pkg.sv
// Shared definitions for the parametrised serial sequence detector.
package seq_detect_param_pkg;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    // Bits needed to hold the values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating event counter with a registered all-ones flag.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_n;

    always_comb begin
        cnt_n = cnt + {{(W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc && !sat) begin
            cnt <= cnt_n;
            sat <= &cnt_n;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector: programmable PAT_W-bit pattern, valid-gated input,
// overlapping or non-overlapping matching and a saturating match counter.
module seq_detect_param
    import seq_detect_param_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             X,
    input  logic             x_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int                FILL_W   = clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist, hist_n;
    logic [FILL_W-1:0] fill, fill_n;
    logic              hit_p0;
    logic              vld_p0;

    // Stage 0: candidate next history and match decision for the incoming bit
    always_comb begin
        hist_n = {hist[PAT_W-2:0], X};
        fill_n = (fill == FILL_MAX) ? FILL_MAX : fill + {{(FILL_W-1){1'b0}}, 1'b1};
        hit_p0 = (fill_n == FILL_MAX) && (hist_n == pattern);
        vld_p0 = x_valid && !rst && !clr;
    end

    // Stage 1: commit history; non-overlap restarts the fill so the next match
    // needs PAT_W fresh bits, while the stale history is simply left in place.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= '0;
            fill <= '0;
            out  <= 1'b0;
        end else if (x_valid) begin
            hist <= hist_n;
            fill <= (hit_p0 && (overlap == MODE_NONOVL)) ? '0 : fill_n;
            out  <= hit_p0;
        end else begin
            out  <= 1'b0;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (vld_p0 && hit_p0),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: three instances cover the
// default width, a narrow saturating counter and a 4-bit pattern.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0, clr = 1'b0, X = 1'b0, x_valid = 1'b0, overlap = 1'b1;
    logic [2:0] pat3 = 3'b111;
    logic [1:0] pat2 = 2'b11;
    logic [3:0] pat4 = 4'b1100;

    logic       out3, sat3, out2, sat2, out4, sat4;
    logic [7:0] cnt3, cnt4;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(3), .CNT_W(8)) u3 (
        .clk(clk), .rst(rst), .X(X), .x_valid(x_valid), .pattern(pat3), .overlap(overlap),
        .clr(clr), .out(out3), .match_cnt(cnt3), .cnt_sat(sat3));
    seq_detect_param #(.PAT_W(2), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .X(X), .x_valid(x_valid), .pattern(pat2), .overlap(overlap),
        .clr(clr), .out(out2), .match_cnt(cnt2), .cnt_sat(sat2));
    seq_detect_param #(.PAT_W(4), .CNT_W(8)) u4 (
        .clk(clk), .rst(rst), .X(X), .x_valid(x_valid), .pattern(pat4), .overlap(overlap),
        .clr(clr), .out(out4), .match_cnt(cnt4), .cnt_sat(sat4));

    typedef struct {
        logic o;
        int   c;
        logic s;
    } exp_t;

    exp_t  sbq[$];
    logic  acc[$];
    int    checks = 0, errors = 0;
    int    sel = 3, pw = 3, cw = 8, mcnt = 0, nacc = 0;
    logic [31:0] pmask = '0;

    task automatic select(input int s);
        sel = s;
        pw  = (s == 2) ? 2 : s;
        cw  = (s == 2) ? 2 : 8;
    endtask

    // Reference: remember accepted bits since the last clear (or since the
    // last non-overlapping match) and compare the newest pw of them.
    task automatic step(input logic r, input logic c, input logic v, input logic x);
        exp_t e, got;
        logic [15:0] mpat;
        logic matched;
        int   maxc;
        rst = r; clr = c; x_valid = v; X = x;
        mpat = (sel == 2) ? 16'(pat2) : (sel == 4) ? 16'(pat4) : 16'(pat3);
        maxc = (1 << cw) - 1;
        e.o = 1'b0;
        if (r || c) begin
            acc.delete();
            mcnt  = 0;
            nacc  = 0;
            pmask = '0;
        end else if (v) begin
            acc.push_back(x);
            nacc++;
            if (acc.size() >= pw) begin
                matched = 1'b1;
                for (int k = 0; k < pw; k++)
                    if (acc[acc.size() - 1 - k] !== mpat[k]) matched = 1'b0;
                if (matched) begin
                    e.o = 1'b1;
                    if (mcnt < maxc) mcnt++;
                    if (!overlap) acc.delete();
                end
            end
        end
        e.c = mcnt;
        e.s = (mcnt == maxc);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        case (sel)
            2:       begin e.o = out2; e.c = int'(cnt2); e.s = sat2; end
            4:       begin e.o = out4; e.c = int'(cnt4); e.s = sat4; end
            default: begin e.o = out3; e.c = int'(cnt3); e.s = sat3; end
        endcase
        if (e.o === 1'b1) pmask[nacc] = 1'b1;
        checks += 3;
        if (e.o !== got.o) begin
            errors++;
            $display("FAIL out sel=%0d bit=%0d got %b want %b", sel, nacc, e.o, got.o);
        end
        if (e.c !== got.c) begin
            errors++;
            $display("FAIL match_cnt sel=%0d bit=%0d got %0d want %0d", sel, nacc, e.c, got.c);
        end
        if (e.s !== got.s) begin
            errors++;
            $display("FAIL cnt_sat sel=%0d bit=%0d got %b want %b", sel, nacc, e.s, got.s);
        end
    endtask

    task automatic expect_mask(input string name, input logic [31:0] want);
        checks++;
        if (pmask !== want) begin
            errors++;
            $display("FAIL %s pulse_mask got %h want %h", name, pmask, want);
        end
    endtask

    task automatic expect_cnt(input string name, input int want_c, input logic want_s);
        int   c;
        logic s;
        c = (sel == 2) ? int'(cnt2) : (sel == 4) ? int'(cnt4) : int'(cnt3);
        s = (sel == 2) ? sat2 : (sel == 4) ? sat4 : sat3;
        checks++;
        if (c !== want_c || s !== want_s) begin
            errors++;
            $display("FAIL %s cnt/sat got %0d/%b want %0d/%b", name, c, s, want_c, want_s);
        end
    endtask

    task automatic test_reset();
        select(3);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({out3, cnt3, sat3, out2, cnt2, sat2, out4, cnt4, sat4} !== '0) begin
            errors++;
            $display("FAIL reset_state got %b want 0",
                     {out3, cnt3, sat3, out2, cnt2, sat2, out4, cnt4, sat4});
        end
    endtask

    task automatic test_legacy();
        logic [11:0] s;
        s = 12'b0110_1110_1001;
        select(3); pat3 = 3'b111; overlap = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 11; i >= 0; i--) step(1'b0, 1'b0, 1'b1, s[i]);
        expect_mask("legacy", 32'h0000_0080);
        expect_cnt("legacy", 1, 1'b0);
    endtask

    task automatic test_six_ones(input logic ovl, input logic [31:0] want_mask, input int want_c);
        select(3); pat3 = 3'b111; overlap = ovl;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        expect_mask(ovl ? "six_ones_ovl" : "six_ones_nonovl", want_mask);
        expect_cnt(ovl ? "six_ones_ovl" : "six_ones_nonovl", want_c, 1'b0);
    endtask

    task automatic test_gapped();
        select(3); pat3 = 3'b101; overlap = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        expect_mask("gapped", 32'h0000_0028);
        expect_cnt("gapped", 2, 1'b0);
    endtask

    task automatic test_clear_mid(input logic use_rst);
        select(3); pat3 = 3'b111; overlap = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        expect_mask(use_rst ? "rst_pre" : "clr_pre", 32'h0);
        step(use_rst, !use_rst, 1'b1, 1'b1);
        expect_cnt(use_rst ? "rst_mid" : "clr_mid", 0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        expect_mask(use_rst ? "rst_post" : "clr_post", 32'h0000_0008);
        expect_cnt(use_rst ? "rst_post" : "clr_post", 1, 1'b0);
    endtask

    task automatic test_saturation();
        select(2); pat2 = 2'b11; overlap = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        expect_mask("saturation", 32'h0000_007C);
        expect_cnt("saturation", 3, 1'b1);
    endtask

    task automatic test_pattern_change();
        select(4); pat4 = 4'b1100; overlap = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        pat4 = 4'b1111;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        expect_mask("pattern_change", 32'h0000_0010);
        expect_cnt("pattern_change", 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_six_ones(1'b1, 32'h0000_0078, 4);
        test_six_ones(1'b0, 32'h0000_0048, 2);
        test_gapped();
        test_clear_mid(1'b0);
        test_clear_mid(1'b1);
        test_saturation();
        test_pattern_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial sequence detector; successor to the fixed three-ones detector.
- Detects a run-time programmable PAT_W-bit pattern on a one-bit serial stream, gated by a valid qualifier.
- Selectable overlapping or non-overlapping match mode; counts matches in a saturating counter.
- Sits at the serial-input front end of the practice datapath; `out` feeds downstream event logic.

Parameters:
- PAT_W, 3, pattern length in bits (legal range 2..16).
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- X  input  1  serial data bit.
- x_valid  input  1  X is sampled only on edges where x_valid=1.
- pattern  input  PAT_W  target sequence; pattern[PAT_W-1] is the oldest bit, pattern[0] the newest.
- overlap  input  1  1=overlapping mode, 0=non-overlapping mode.
- clr  input  1  synchronous soft clear.
- out  output  1  one-cycle match pulse, registered.
- match_cnt  output  CNT_W  number of matches since reset/clr, saturating.
- cnt_sat  output  1  high while match_cnt is all-ones.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst; rst has priority over clr, clr has priority over x_valid.
- Reset/clr values: hist=0, fill=0, out=0, match_cnt=0, cnt_sat=0.
- State:
  - hist[PAT_W-1:0] is the shift history; newest bit enters at LSB.
  - fill counts accepted bits, 0..PAT_W, and saturates at PAT_W.
- Accepted bit (x_valid=1 and no rst/clr):
  - hist_n = {hist[PAT_W-2:0], X}.
  - fill_n = min(fill+1, PAT_W).
- Match condition, evaluated on hist_n and fill_n: (fill_n==PAT_W) and (hist_n==pattern).
- On a match:
  - out is 1 in the cycle after the edge that sampled the completing bit (registered, latency 1).
  - match_cnt increments unless already all-ones.
- Mode on match:
  - overlap=1: fill stays at PAT_W, so the next accepted bit can complete another match.
  - overlap=0: fill_n forced to 0 and hist retains its value, so the next match needs PAT_W fresh bits.
- x_valid=0: hist, fill and match_cnt hold, and out returns to 0. out never stays high for two cycles unless two consecutive accepted bits each match.
- pattern and overlap are sampled combinationally on every accepted bit. Changing them does not clear history; the new value applies from the next accepted bit.
- cnt_sat = &match_cnt, registered alongside match_cnt. A match while saturated still pulses out.
- clr in the same cycle as x_valid=1: the bit is discarded and all state is cleared.
- rst mid-stream: all partial history is lost and fill restarts at 0.
- No matches are possible in the first PAT_W-1 accepted bits after reset/clr, even if hist (reset 0) equals the pattern.

Decomposition:
- Shared include/package:
  - Mode encodings MODE_NONOVL=1'b0 and MODE_OVL=1'b1.
  - A clog2 helper function for sizing fill (width clog2(PAT_W+1)).
- Natural sub-module: sat_counter (parameter W; ports clk, rst, clr, inc, cnt, sat) holds match_cnt/cnt_sat.
- Shift/compare logic stays in the top level.

Test Plan:
- Legacy case, stream X=0,1,1,0,1,1,1,0,1,0,0,1 (x_valid=1 every cycle):
  - PAT_W=3, pattern=3'b111, overlap=1.
  - Expect a single out pulse the cycle after the 7th bit; match_cnt=1.
- Six consecutive 1s, pattern=111:
  - overlap=1 -> pulses after bits 3,4,5,6; match_cnt=4.
  - overlap=0 -> pulses after bits 3 and 6; match_cnt=2.
- Gapped stream, pattern=3'b101, overlap=1:
  - Bits 1,0,1 with x_valid toggling 1,0,1,0,1.
  - Expect one pulse after the final accepted 1; no pulse on idle cycles.
  - Next accepted bits 0,1 give a second match (overlap via 101 -> 01 + 01).
- Reset/clear mid-operation, pattern=111:
  - Apply 1,1 then clr=1 together with x_valid=1, X=1.
  - Expect no pulse, match_cnt=0, fill=0.
  - Then 1,1,1 -> pulse after the 3rd bit.
  - Repeat the same sequence using rst instead of clr; identical result.
- Saturation, CNT_W=2, pattern=11, overlap=1:
  - Feed six 1s -> pulses after bits 2..6.
  - match_cnt goes 1,2,3 then holds at 3; cnt_sat=1 from the third match on.
- Pattern change on the fly, PAT_W=4, pattern=1100:
  - Feed 1,1 then switch pattern to 1111 and feed 1,1.
  - Expect a pulse after the 4th bit (history retained); no pulse for the old pattern.
